// File: rtl/shoot_seq_ctrl.sv
// shoot_seq_ctrl
//
// Turret sequencing and arbitration controller. Owns the turret motor
// direction codes and the trigger servo start line, and shares the turret
// between the manual debounced push-buttons and an autonomous
// request/acknowledge port.
//
// Ports:
//   i_clk, i_rst          system clock, synchronous active-high reset
//   i_man_turn            manual turn, active while held
//   i_man_turn_back       manual turn back, active while held
//   i_man_fire            manual fire, rising edge requests one shot
//   i_auto_req            auto request valid, held until o_auto_ack
//   i_auto_op[1:0]        00 nop, 01 turn, 10 turn back, 11 fire
//   i_auto_len[7:0]       turn steps for ops 01/10
//   o_auto_ack            one-cycle pulse, auto request accepted
//   o_auto_done           one-cycle pulse, accepted request finished
//   o_auto_err            valid with o_auto_done, 1 = aborted or refused
//   o_left[1:0]           turret motor left code
//   o_right[1:0]          turret motor right code
//   o_servo_start         trigger servo start level
//   o_busy                high whenever the controller is not idle
//   o_shot_cnt[7:0]       shots fired since reset, saturating
//
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state register.

module shoot_seq_ctrl #(
    parameter int TURN_STEP_CYC = 5_000_000,
    parameter int FIRE_HOLD_CYC = 50_000_000,
    parameter int COOLDOWN_CYC  = 100_000_000,
    parameter int MAX_SHOTS     = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_man_turn,
    input  logic       i_man_turn_back,
    input  logic       i_man_fire,
    input  logic       i_auto_req,
    input  logic [1:0] i_auto_op,
    input  logic [7:0] i_auto_len,
    output logic       o_auto_ack,
    output logic       o_auto_done,
    output logic       o_auto_err,
    output logic [1:0] o_left,
    output logic [1:0] o_right,
    output logic       o_servo_start,
    output logic       o_busy,
    output logic [7:0] o_shot_cnt
);

    typedef enum logic [2:0] {
        IDLE, MAN_TURN, MAN_BACK, AUTO_TURN, AUTO_BACK, FIRE, COOLDOWN, DONE
    } state_t;

    localparam logic [31:0] STEP_LAST = 32'(TURN_STEP_CYC - 1);
    localparam logic [31:0] FIRE_LAST = 32'(FIRE_HOLD_CYC - 1);
    localparam logic [31:0] COOL_LAST = 32'(COOLDOWN_CYC - 1);
    localparam logic [7:0]  SHOT_MAX  = 8'(MAX_SHOTS);

    localparam logic [3:0] CODE_STOP = 4'b1111;
    localparam logic [3:0] CODE_TURN = 4'b1011;
    localparam logic [3:0] CODE_BACK = 4'b0111;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_cyc;
    logic [7:0]  r_steps;
    logic        r_fire_prev;
    logic        r_auto_own;
    logic [7:0]  r_shot_cnt;

    logic        w_fire_rise;
    logic        w_full;
    logic        w_fire_req;
    logic        w_man_one;
    logic        w_man_any;
    logic        w_auto_accept;
    logic        w_err_next;
    logic        w_turn_last;
    logic [3:0]  w_code;
    logic        w_servo;
    logic        w_busy;
    logic        w_done;

    assign w_fire_rise = i_man_fire & ~r_fire_prev;
    assign w_full      = (r_shot_cnt >= SHOT_MAX);
    // A manual fire edge with an empty magazine is not a request at all,
    // so lower-priority requests can still be served in that cycle.
    assign w_fire_req  = w_fire_rise & ~w_full;
    assign w_man_one   = i_man_turn ^ i_man_turn_back;
    assign w_man_any   = i_man_turn | i_man_turn_back;
    assign w_turn_last = (r_cyc == STEP_LAST) && (r_steps == 8'd1);
    assign w_auto_accept = (r_state == IDLE) && !w_fire_req && !w_man_one && i_auto_req;

    // State register plus the registered outputs decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            o_left        <= CODE_STOP[3:2];
            o_right       <= CODE_STOP[1:0];
            o_servo_start <= 1'b0;
            o_busy        <= 1'b0;
            o_auto_ack    <= 1'b0;
            o_auto_done   <= 1'b0;
            o_auto_err    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            o_left        <= w_code[3:2];
            o_right       <= w_code[1:0];
            o_servo_start <= w_servo;
            o_busy        <= w_busy;
            o_auto_ack    <= w_auto_accept;
            o_auto_done   <= w_done;
            o_auto_err    <= w_done & w_err_next;
        end
    end

    // Datapath: the cycle counter restarts on every state change and, inside
    // the auto turn states, at every step boundary while the step counter
    // walks down from the latched length. The fire edge detector runs in
    // every state; edges outside IDLE are simply never acted on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc       <= 32'd0;
            r_steps     <= 8'd0;
            r_fire_prev <= 1'b0;
            r_auto_own  <= 1'b0;
            r_shot_cnt  <= 8'd0;
        end else begin
            r_fire_prev <= i_man_fire;
            if (r_state != w_next_state) begin
                r_cyc <= 32'd0;
            end else if ((r_state == AUTO_TURN || r_state == AUTO_BACK) && r_cyc == STEP_LAST) begin
                r_cyc   <= 32'd0;
                r_steps <= r_steps - 8'd1;
            end else begin
                r_cyc <= r_cyc + 32'd1;
            end
            if (w_auto_accept) begin
                r_steps    <= i_auto_len;
                r_auto_own <= 1'b1;
            end else if (r_state == IDLE && (w_fire_req || w_man_one)) begin
                r_auto_own <= 1'b0;
            end
            if (w_next_state == FIRE && r_state != FIRE && !w_full) begin
                r_shot_cnt <= r_shot_cnt + 8'd1;
            end
        end
    end

    // Next-state logic. IDLE arbitrates manual fire, then a single manual
    // turn button, then the auto port. w_err_next is the error flag that
    // accompanies an entry into DONE.
    always_comb begin
        w_next_state = r_state;
        w_err_next   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_fire_req) begin
                    w_next_state = FIRE;
                end else if (w_man_one) begin
                    w_next_state = i_man_turn ? MAN_TURN : MAN_BACK;
                end else if (i_auto_req) begin
                    unique case (i_auto_op)
                        2'b01:   w_next_state = (i_auto_len != 8'd0) ? AUTO_TURN : DONE;
                        2'b10:   w_next_state = (i_auto_len != 8'd0) ? AUTO_BACK : DONE;
                        2'b11: begin
                            w_next_state = w_full ? DONE : FIRE;
                            w_err_next   = w_full;
                        end
                        default: w_next_state = DONE;
                    endcase
                end
            end
            MAN_TURN: begin
                if (!(i_man_turn && !i_man_turn_back)) w_next_state = IDLE;
            end
            MAN_BACK: begin
                if (!(i_man_turn_back && !i_man_turn)) w_next_state = IDLE;
            end
            AUTO_TURN, AUTO_BACK: begin
                if (w_man_any) begin
                    w_next_state = DONE;
                    w_err_next   = 1'b1;
                end else if (w_turn_last) begin
                    w_next_state = DONE;
                end
            end
            FIRE: begin
                if (r_cyc == FIRE_LAST) w_next_state = COOLDOWN;
            end
            COOLDOWN: begin
                if (r_cyc == COOL_LAST) w_next_state = r_auto_own ? DONE : IDLE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode from the next state; the results are registered above.
    always_comb begin
        w_code  = CODE_STOP;
        w_servo = (w_next_state == FIRE);
        w_busy  = (w_next_state != IDLE);
        w_done  = (w_next_state == DONE);
        if (w_next_state == MAN_TURN || w_next_state == AUTO_TURN) begin
            w_code = CODE_TURN;
        end else if (w_next_state == MAN_BACK || w_next_state == AUTO_BACK) begin
            w_code = CODE_BACK;
        end
    end

    assign o_shot_cnt = r_shot_cnt;

endmodule

// File: tb/tb_shoot_seq_ctrl.sv
// tb_shoot_seq_ctrl
//
// Directed bench for shoot_seq_ctrl with short timing parameters
// (TURN_STEP_CYC=4, FIRE_HOLD_CYC=10, COOLDOWN_CYC=20, MAX_SHOTS=3).
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_shoot_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       man_turn;
    logic       man_turn_back;
    logic       man_fire;
    logic       auto_req;
    logic [1:0] auto_op;
    logic [7:0] auto_len;
    logic       auto_ack;
    logic       auto_done;
    logic       auto_err;
    logic [1:0] left;
    logic [1:0] right;
    logic       servo_start;
    logic       busy;
    logic [7:0] shot_cnt;

    int compareCount  = 0;
    int mismatchCount = 0;

    shoot_seq_ctrl #(
        .TURN_STEP_CYC(4),
        .FIRE_HOLD_CYC(10),
        .COOLDOWN_CYC (20),
        .MAX_SHOTS    (3)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_man_turn     (man_turn),
        .i_man_turn_back(man_turn_back),
        .i_man_fire     (man_fire),
        .i_auto_req     (auto_req),
        .i_auto_op      (auto_op),
        .i_auto_len     (auto_len),
        .o_auto_ack     (auto_ack),
        .o_auto_done    (auto_done),
        .o_auto_err     (auto_err),
        .o_left         (left),
        .o_right        (right),
        .o_servo_start  (servo_start),
        .o_busy         (busy),
        .o_shot_cnt     (shot_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every request input at once.
    task automatic applyStimulus(input logic req, input logic [1:0] op, input logic [7:0] len,
                                 input logic turn, input logic back, input logic fire);
        auto_req      = req;
        auto_op       = op;
        auto_len      = len;
        man_turn      = turn;
        man_turn_back = back;
        man_fire      = fire;
    endtask

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Directed scenarios, each with hand-computed expectations.
    initial begin
        int n;
        logic sawAck;

        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rstCode",  {left, right}, 4'b1111);
        checkOutput("rstServo", servo_start, 1'b0);
        checkOutput("rstBusy",  busy, 1'b0);
        checkOutput("rstAck",   auto_ack, 1'b0);
        checkOutput("rstDone",  auto_done, 1'b0);
        checkOutput("rstErr",   auto_err, 1'b0);
        checkOutput("rstShot",  shot_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // Auto turn, three steps of four cycles.
        applyStimulus(1'b1, 2'b01, 8'd3, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t1Ack",  auto_ack, 1'b1);
        checkOutput("t1Busy", busy, 1'b1);
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        n = ({left, right} == 4'b1011) ? 1 : 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if ({left, right} == 4'b1011) n++;
            else break;
        end
        checkOutput("t1TurnCycles", n, 12);
        checkOutput("t1Done", auto_done, 1'b1);
        checkOutput("t1Err",  auto_err, 1'b0);
        checkOutput("t1Stop", {left, right}, 4'b1111);
        tick();
        checkOutput("t1Idle", busy, 1'b0);

        // Manual fire with a second edge during the hold that must be ignored.
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("t2Servo", servo_start, 1'b1);
        checkOutput("t2Shot",  shot_cnt, 8'd1);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            if (i == 2) man_fire = 1'b0;
            if (i == 4) man_fire = 1'b1;
            tick();
            if (servo_start) n++;
            else break;
        end
        checkOutput("t2HoldCycles", n, 10);
        man_fire = 1'b0;
        n = busy ? 1 : 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy && !servo_start) n++;
            else break;
        end
        checkOutput("t2CoolCycles", n, 20);
        checkOutput("t2ShotAfter",  shot_cnt, 8'd1);
        checkOutput("t2NoDone",     auto_done, 1'b0);
        tick();
        checkOutput("t2StillIdle",  busy, 1'b0);

        // Auto turn back aborted by the manual turn button.
        applyStimulus(1'b1, 2'b10, 8'd5, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t3Ack",  auto_ack, 1'b1);
        checkOutput("t3Code", {left, right}, 4'b0111);
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("t3Code5", {left, right}, 4'b0111);
        man_turn = 1'b1;
        tick();
        checkOutput("t3AbortCode", {left, right}, 4'b1111);
        checkOutput("t3AbortDone", auto_done, 1'b1);
        checkOutput("t3AbortErr",  auto_err, 1'b1);
        tick();
        checkOutput("t3IdleBusy", busy, 1'b0);
        tick();
        checkOutput("t3ManCode", {left, right}, 4'b1011);
        checkOutput("t3ManBusy", busy, 1'b1);
        man_turn = 1'b0;
        tick();
        checkOutput("t3RelCode", {left, right}, 4'b1111);
        checkOutput("t3RelBusy", busy, 1'b0);

        // Clear the shot count, then four auto fires against a three-shot magazine.
        rst = 1'b1;
        tick();
        checkOutput("t4RstShot", shot_cnt, 8'd0);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 2'b11, 8'd0, 1'b0, 1'b0, 1'b0);
            tick();
            checkOutput("t4Ack", auto_ack, 1'b1);
            applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
            if (k < 3) begin
                checkOutput("t4Servo", servo_start, 1'b1);
                checkOutput("t4Shot",  shot_cnt, k + 1);
                for (int i = 0; i < 100; i++) begin
                    tick();
                    if (auto_done) break;
                end
                checkOutput("t4Done",      auto_done, 1'b1);
                checkOutput("t4Err",       auto_err, 1'b0);
                checkOutput("t4DoneServo", servo_start, 1'b0);
            end else begin
                checkOutput("t4RefServo", servo_start, 1'b0);
                checkOutput("t4RefDone",  auto_done, 1'b1);
                checkOutput("t4RefErr",   auto_err, 1'b1);
                checkOutput("t4RefShot",  shot_cnt, 8'd3);
            end
            tick();
            checkOutput("t4Idle", busy, 1'b0);
        end

        // Fire, manual turn and auto request in the same idle cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        applyStimulus(1'b1, 2'b01, 8'd2, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("t5Servo", servo_start, 1'b1);
        checkOutput("t5NoAck", auto_ack, 1'b0);
        checkOutput("t5Code",  {left, right}, 4'b1111);
        sawAck = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (auto_ack) sawAck = 1'b1;
            if (!busy) break;
        end
        checkOutput("t5IdleBusy", busy, 1'b0);
        tick();
        if (auto_ack) sawAck = 1'b1;
        checkOutput("t5ManCode", {left, right}, 4'b1011);
        checkOutput("t5NoAckYet", sawAck, 1'b0);
        man_turn = 1'b0;
        man_fire = 1'b0;
        tick();
        checkOutput("t5RelBusy", busy, 1'b0);
        tick();
        checkOutput("t5LateAck",  auto_ack, 1'b1);
        checkOutput("t5LateCode", {left, right}, 4'b1011);
        auto_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (auto_done) break;
        end
        checkOutput("t5LateDone", auto_done, 1'b1);
        checkOutput("t5LateErr",  auto_err, 1'b0);
        tick();

        // Reset in the middle of a shot.
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("t6Servo", servo_start, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        man_fire = 1'b0;
        tick();
        checkOutput("t6RstServo", servo_start, 1'b0);
        checkOutput("t6RstShot",  shot_cnt, 8'd0);
        checkOutput("t6RstBusy",  busy, 1'b0);
        checkOutput("t6RstCode",  {left, right}, 4'b1111);
        rst = 1'b0;
        tick();

        // Zero-length auto turn completes without motion.
        applyStimulus(1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t6ZeroAck",  auto_ack, 1'b1);
        checkOutput("t6ZeroDone", auto_done, 1'b1);
        checkOutput("t6ZeroErr",  auto_err, 1'b0);
        checkOutput("t6ZeroCode", {left, right}, 4'b1111);
        auto_req = 1'b0;
        tick();
        checkOutput("t6ZeroIdle", busy, 1'b0);
        checkOutput("t6ZeroNoAck", auto_ack, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/shoot_seq_ctrl.md
# shoot_seq_ctrl

Sequencing and arbitration controller for the car's turret: owns the turn-motor direction codes and the trigger-servo start line. Shares the turret between two requesters, the manual debounced push-buttons and an autonomous request/acknowledge port. Sits between the button debouncers / auto logic and the SG90 servo and turret motor driver.

## Interface
- TURN_STEP_CYC, 5_000_000: cycles per turn step (auto turns are multiples of this).
- FIRE_HOLD_CYC, 50_000_000: cycles servo_start is held high per shot.
- COOLDOWN_CYC, 100_000_000: idle cycles forced after each shot.
- MAX_SHOTS, 6: magazine size; fire refused once shot_cnt reaches it.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- man_turn  in  1  debounced level; turn while held.
- man_turn_back  in  1  debounced level; turn opposite while held.
- man_fire  in  1  debounced level; rising edge requests one shot.
- auto_req  in  1  auto request valid; held until auto_ack.
- auto_op  in  2  00 nop, 01 turn, 10 turn back, 11 fire.
- auto_len  in  8  turn steps for ops 01/10; ignored otherwise.
- auto_ack  out  1  one-cycle pulse: request accepted.
- auto_done  out  1  one-cycle pulse: accepted request finished.
- auto_err  out  1  valid with auto_done; 1 = aborted or refused.
- left  out  2  turret motor left code.
- right  out  2  turret motor right code.
- servo_start  out  1  trigger servo start level.
- busy  out  1  high whenever state is not IDLE.
- shot_cnt  out  8  shots fired since reset.

## Operation
- States: IDLE, MAN_TURN, MAN_BACK, AUTO_TURN, AUTO_BACK, FIRE, COOLDOWN, DONE.
- Motor codes {left,right}: stop 4'b1111, turn 4'b1011, turn back 4'b0111. Stop in every state except the turn states.
- IDLE priority, highest first: man_fire rising edge; man_turn xor man_turn_back; auto_req. Both turn buttons high = no manual request.
- man_fire edge detector runs continuously, but edges outside IDLE are dropped, not queued.
- MAN_TURN/MAN_BACK: drive the code while the button is held. On release, or when the other button also goes high, return to IDLE.
- Auto accept: auto_ack pulses and the op is latched. Ops:
  - 01/10: AUTO_TURN/AUTO_BACK for auto_len*TURN_STEP_CYC cycles, then DONE.
  - 11: FIRE.
  - 00, or auto_len==0 for 01/10: DONE directly, err=0.
- Manual turn button pressed during AUTO_TURN/AUTO_BACK: abort. Go to DONE with err=1, then IDLE, so manual can take over. FIRE and COOLDOWN cannot be aborted.
- FIRE entry: shot_cnt increments and servo_start is high for FIRE_HOLD_CYC cycles. Then COOLDOWN for COOLDOWN_CYC cycles, then DONE if auto-owned, else IDLE.
- Fire while shot_cnt==MAX_SHOTS:
  - Manual: ignored.
  - Auto: acked, then DONE with err=1. No servo activity.
- DONE: one cycle with auto_done=1, then IDLE.
- shot_cnt saturates at MAX_SHOTS and clears only on rst.

## Timing
- All outputs are registered. On rst: state IDLE, {left,right}=4'b1111, and servo_start, busy, auto_ack, auto_done, auto_err and shot_cnt all 0. The edge detector's previous-value register is cleared to 0.
- Request seen in IDLE at edge N gives, from edge N+1: new state, motor code / servo_start, busy=1, and auto_ack (auto requests).
- Turn code is held for exactly auto_len*TURN_STEP_CYC cycles. auto_done is asserted on the first cycle the code is back to 4'b1111.
- servo_start is high for exactly FIRE_HOLD_CYC cycles, then low for COOLDOWN_CYC cycles before DONE or IDLE.
- Manual release sampled at edge N gives stop code and busy=0 from edge N+1.
- Abort: button sampled at edge N gives stop code and auto_done=auto_err=1 at N+1, then busy=0 at N+2.
- Earliest re-accept is the cycle after busy falls. The auto source must drop auto_req after auto_ack, or it is taken as a new request.
- rst mid-operation forces reset values at the next edge. No pending done pulse is emitted.
- Counter widths must be sufficient for the defaults: 32-bit cycle counter, 8-bit step counter.

## Test plan
(Bench overrides: TURN_STEP_CYC=4, FIRE_HOLD_CYC=10, COOLDOWN_CYC=20, MAX_SHOTS=3.)
- auto_req with op=01, len=3 -> ack next cycle; code 4'b1011 for exactly 12 cycles; then done=1, err=0, code 4'b1111.
- man_fire rising edge in IDLE -> servo_start high for 10 cycles, low for 20 cycles, shot_cnt=1. A second edge during the sequence is ignored.
- auto op=10, len=5; man_turn pressed at cycle 6 -> stop plus done=1, err=1 next cycle; then 4'b1011 while the button is held.
- Four auto fire requests -> shot_cnt=3 after the third. The fourth is acked with done/err=1 and servo_start stays 0.
- man_fire edge, man_turn and auto_req all in the same IDLE cycle -> fire wins, no ack. Afterwards the still-held auto_req is served only if no manual request is present.
- rst during FIRE -> next cycle servo_start=0, shot_cnt=0, busy=0, code 4'b1111. Auto op=01 with len=0 -> ack then done, err=0, no motion.
